// File: rtl/inv_mix_col_sched_if.sv
// Request/response bus between the two requesters and the
// InvMixColumns column scheduler.
interface inv_mix_col_sched_if;
    logic         Req0Valid;
    logic [127:0] Req0Data;
    logic         Req0Ready;
    logic         Req1Valid;
    logic [127:0] Req1Data;
    logic         Req1Ready;
    logic         Resp0Valid;
    logic         Resp1Valid;
    logic [127:0] RespData;

    modport master (
        output Req0Valid, Req0Data, Req1Valid, Req1Data,
        input  Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, RespData
    );

    modport slave (
        input  Req0Valid, Req0Data, Req1Valid, Req1Data,
        output Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, RespData
    );
endinterface

// File: rtl/inv_mix_col_sched.sv
// Two-port round-robin scheduler streaming 128-bit blocks column by
// column through one shared InvMixColumns unit of latency COL_LAT.
module inv_mix_col_sched #(
    parameter int COL_LAT = 3
) (
    input  logic                      Clk,
    input  logic                      Rst,
    inv_mix_col_sched_if.slave        bus,
    output logic [31:0]               ColUnitIn,
    input  logic [31:0]               ColUnitOut,
    output logic                      Busy
);

    localparam int KW = $clog2(COL_LAT + 4);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [KW-1:0] K_LAT  = KW'(COL_LAT);
    localparam logic [KW-1:0] K_LAST = KW'(COL_LAT + 3);

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic [KW-1:0] k_q, k_d;
    logic [127:0]  blk_q, blk_d;
    logic [127:0]  res_q, res_d;
    logic [127:0]  rdata_q, rdata_d;

    logic acc0, acc1;

    assign bus.Req0Ready = !Rst && state_q == IDLE && bus.Req0Valid &&
                           (!bus.Req1Valid || !ptr_q);
    assign bus.Req1Ready = !Rst && state_q == IDLE && bus.Req1Valid &&
                           (!bus.Req0Valid || ptr_q);

    assign acc0 = bus.Req0Valid && bus.Req0Ready;
    assign acc1 = bus.Req1Valid && bus.Req1Ready;

    // Block and result both shift by one column per cycle, so the
    // outgoing column is always the top word and results land in order.
    assign ColUnitIn = (state_q == RUN) ? blk_q[127:96] : 32'h0;

    assign bus.Resp0Valid = state_q == DONE && !owner_q;
    assign bus.Resp1Valid = state_q == DONE &&  owner_q;
    assign bus.RespData   = rdata_q;
    assign Busy           = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        k_d     = k_q;
        blk_d   = blk_q;
        res_d   = res_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    state_d = RUN;
                    owner_d = acc1;
                    ptr_d   = !acc1;
                    k_d     = '0;
                    blk_d   = acc1 ? bus.Req1Data : bus.Req0Data;
                end
            end
            RUN: begin
                blk_d = {blk_q[95:0], 32'h0};
                if (k_q >= K_LAT) begin
                    res_d = {res_q[95:0], ColUnitOut};
                end
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    rdata_d = res_d;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            k_q     <= '0;
            blk_q   <= '0;
            res_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            k_q     <= k_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
